// File: rtl/branch_pattern_table_pkg.sv
// Shared types and defaults for the branch pattern table.
// Holds the FSM state encoding and the default counter width.
package bp_pkg;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } bp_state_e;

   localparam int CTR_W_DEF = 2;

endpackage

// File: rtl/branch_pattern_table_if.sv
// Request/response bundle of the branch pattern table.
// The master side issues lookups, updates and flushes; the slave side is the table.
interface branch_pattern_table_if #(
   parameter int CTR_W = 2,
   parameter int IDX_W = 8
);

   logic             flush;
   logic             ready;
   logic             lk_valid;
   logic [IDX_W-1:0] lk_idx;
   logic             pred_valid;
   logic             pred_taken;
   logic [CTR_W-1:0] pred_ctr;
   logic             upd_valid;
   logic [IDX_W-1:0] upd_idx;
   logic             upd_taken;

   modport master (
      output flush, lk_valid, lk_idx, upd_valid, upd_idx, upd_taken,
      input  ready, pred_valid, pred_taken, pred_ctr
   );

   modport slave (
      input  flush, lk_valid, lk_idx, upd_valid, upd_idx, upd_taken,
      output ready, pred_valid, pred_taken, pred_ctr
   );

endinterface

// File: rtl/branch_pattern_table_sat_counter.sv
// Saturating up/down counter step: the only place the saturation rule lives.
// Purely combinational: taken counts up to all-ones, not-taken counts down to zero.
module sat_counter #(
   parameter int CTR_W = 2
) (
   input  logic [CTR_W-1:0] cur,
   input  logic             taken,
   output logic [CTR_W-1:0] nxt
);

   localparam logic [CTR_W-1:0] CTR_MAX = '1;
   localparam logic [CTR_W-1:0] CTR_MIN = '0;

   always_comb begin
      // NOTE: default first so every path assigns nxt; otherwise a latch is inferred.
      nxt = cur;
      if (taken) begin
         if (cur != CTR_MAX) nxt = cur + CTR_W'(1);
      end else begin
         if (cur != CTR_MIN) nxt = cur - CTR_W'(1);
      end
   end

endmodule

// File: rtl/branch_pattern_table.sv
// Table of saturating branch-direction counters with a one-entry-per-cycle init sweep,
// registered lookup results and same-cycle update-to-lookup bypass.
module branch_pattern_table
   import bp_pkg::*;
#(
   parameter int   CTR_W    = CTR_W_DEF,
   parameter int   ENTRIES  = 256,
   parameter int   INIT_VAL = 2**(CTR_W-1)-1,
   localparam int  IDX_W    = $clog2(ENTRIES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   output logic             ready,
   input  logic             lk_valid,
   input  logic [IDX_W-1:0] lk_idx,
   output logic             pred_valid,
   output logic             pred_taken,
   output logic [CTR_W-1:0] pred_ctr,
   input  logic             upd_valid,
   input  logic [IDX_W-1:0] upd_idx,
   input  logic             upd_taken
);

   localparam logic [CTR_W-1:0] INIT_CTR = CTR_W'(INIT_VAL);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES-1);

   bp_state_e        state_q;
   logic [IDX_W-1:0] sweep_q;
   logic             ready_q;
   logic             pred_valid_q;
   logic             pred_taken_q;
   logic [CTR_W-1:0] pred_ctr_q;
   logic [CTR_W-1:0] pred_ctr_d;

   logic [CTR_W-1:0] table_q [ENTRIES];

   logic             lk_acc;
   logic             upd_acc;
   logic             sweep_wr;
   logic [CTR_W-1:0] upd_cur;
   logic [CTR_W-1:0] upd_nxt;

   assign lk_acc   = lk_valid && ready_q;
   assign upd_acc  = upd_valid && ready_q && !flush;
   assign sweep_wr = (state_q == INIT) && !flush;
   assign upd_cur  = table_q[upd_idx];

   sat_counter #(.CTR_W(CTR_W)) u_sat (
      .cur   (upd_cur),
      .taken (upd_taken),
      .nxt   (upd_nxt)
   );

   // A lookup hitting the entry being updated sees the post-update value.
   assign pred_ctr_d = (upd_acc && (upd_idx == lk_idx)) ? upd_nxt : table_q[lk_idx];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= INIT;
         sweep_q      <= '0;
         ready_q      <= 1'b0;
         pred_valid_q <= 1'b0;
         pred_taken_q <= 1'b0;
         pred_ctr_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         pred_valid_q <= lk_acc;
         if (lk_acc) begin
            pred_ctr_q   <= pred_ctr_d;
            pred_taken_q <= pred_ctr_d[CTR_W-1];
         end
         case (state_q)
            INIT: begin
               if (flush) begin
                  sweep_q <= '0;
               end else if (sweep_q == LAST_IDX) begin
                  state_q <= RUN;
                  ready_q <= 1'b1;
                  sweep_q <= '0;
               end else begin
                  sweep_q <= sweep_q + IDX_W'(1);
               end
            end
            RUN: begin
               if (flush) begin
                  state_q <= INIT;
                  ready_q <= 1'b0;
                  sweep_q <= '0;
               end
            end
            default: begin
               state_q <= INIT;
               ready_q <= 1'b0;
               sweep_q <= '0;
            end
         endcase
      end
   end

   // NOTE: storage has no reset; the init sweep defines every entry before first use.
   always_ff @(posedge clk) begin
      if (sweep_wr) begin
         table_q[sweep_q] <= INIT_CTR;
      end else if (upd_acc) begin
         table_q[upd_idx] <= upd_nxt;
      end
   end

   assign ready      = ready_q;
   assign pred_valid = pred_valid_q;
   assign pred_taken = pred_taken_q;
   assign pred_ctr   = pred_ctr_q;

endmodule

// File: tb/tb_branch_pattern_table.sv
// Scoreboard bench: two tables (2-bit and 3-bit counters, 8 entries) share one stimulus stream
// and are checked against an array-of-integers model of saturating counters.
module tb_branch_pattern_table;

   localparam int ENTRIES = 8;
   localparam int IDX_W   = 3;
   localparam int MAX2    = 3;
   localparam int MAX3    = 7;
   localparam int INIT2   = 1;
   localparam int INIT3   = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   branch_pattern_table_if #(.CTR_W(2), .IDX_W(IDX_W)) bus2 ();
   branch_pattern_table_if #(.CTR_W(3), .IDX_W(IDX_W)) bus3 ();

   assign bus3.flush     = bus2.flush;
   assign bus3.lk_valid  = bus2.lk_valid;
   assign bus3.lk_idx    = bus2.lk_idx;
   assign bus3.upd_valid = bus2.upd_valid;
   assign bus3.upd_idx   = bus2.upd_idx;
   assign bus3.upd_taken = bus2.upd_taken;

   branch_pattern_table #(.CTR_W(2), .ENTRIES(ENTRIES)) dut2 (
      .clk(clk), .rst(rst), .flush(bus2.flush), .ready(bus2.ready),
      .lk_valid(bus2.lk_valid), .lk_idx(bus2.lk_idx),
      .pred_valid(bus2.pred_valid), .pred_taken(bus2.pred_taken), .pred_ctr(bus2.pred_ctr),
      .upd_valid(bus2.upd_valid), .upd_idx(bus2.upd_idx), .upd_taken(bus2.upd_taken)
   );

   branch_pattern_table #(.CTR_W(3), .ENTRIES(ENTRIES)) dut3 (
      .clk(clk), .rst(rst), .flush(bus3.flush), .ready(bus3.ready),
      .lk_valid(bus3.lk_valid), .lk_idx(bus3.lk_idx),
      .pred_valid(bus3.pred_valid), .pred_taken(bus3.pred_taken), .pred_ctr(bus3.pred_ctr),
      .upd_valid(bus3.upd_valid), .upd_idx(bus3.upd_idx), .upd_taken(bus3.upd_taken)
   );

   typedef struct {
      int ctr2;
      int ctr3;
      int cyc;
   } exp_t;

   exp_t exp_q[$];
   int   m2 [ENTRIES];
   int   m3 [ENTRIES];
   int   m_init_left;
   bit   m_ready;
   int   cyc;
   int   last2, last3;
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input int req);
      n_tests++;
      if (act !== 32'(req)) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic int sat_step(input int cur, input bit taken, input int max);
      if (taken) return (cur < max) ? cur + 1 : max;
      return (cur > 0) ? cur - 1 : 0;
   endfunction

   task automatic model_fill();
      foreach (m2[i]) begin
         m2[i] = INIT2;
         m3[i] = INIT3;
      end
   endtask

   // One clock of stimulus; called at posedge+1, returns at the following posedge+1.
   task automatic cycle(input bit lk, input int li, input bit up, input int ui,
                        input bit ut, input bit fl);
      bit acc_lk, acc_up;
      bus2.flush     = fl;
      bus2.lk_valid  = lk;
      bus2.lk_idx    = IDX_W'(li);
      bus2.upd_valid = up;
      bus2.upd_idx   = IDX_W'(ui);
      bus2.upd_taken = ut;
      acc_up = up && m_ready && !fl;
      acc_lk = lk && m_ready;
      if (acc_up) begin
         m2[ui] = sat_step(m2[ui], ut, MAX2);
         m3[ui] = sat_step(m3[ui], ut, MAX3);
      end
      if (acc_lk) exp_q.push_back('{ctr2: m2[li], ctr3: m3[li], cyc: cyc + 1});
      @(posedge clk);
      #1;
      cyc++;
      if (fl) begin
         m_ready     = 1'b0;
         m_init_left = ENTRIES;
         model_fill();
      end else if (!m_ready) begin
         m_init_left--;
         if (m_init_left == 0) m_ready = 1'b1;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
   endtask

   // Asserts reset between edges, checks the asynchronous clear, holds, then releases.
   task automatic apply_reset(input int hold);
      rst = 1'b0;
      #1;
      check("rst_ready2", bus2.ready, 0);
      check("rst_ready3", bus3.ready, 0);
      check("rst_pred_valid2", bus2.pred_valid, 0);
      check("rst_pred_valid3", bus3.pred_valid, 0);
      check("rst_pred_taken2", bus2.pred_taken, 0);
      check("rst_pred_ctr2", bus2.pred_ctr, 0);
      check("rst_pred_ctr3", bus3.pred_ctr, 0);
      exp_q.delete();
      m_ready = 1'b0;
      last2   = 0;
      last3   = 0;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      rst = 1'b1;
      m_init_left = ENTRIES;
      model_fill();
   endtask

   // Monitor: compares ready every cycle and pops the scoreboard on each prediction.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         check("ready2", bus2.ready, int'(m_ready));
         check("ready3", bus3.ready, int'(m_ready));
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            check("missing_pred", 0, 1);
            void'(exp_q.pop_front());
         end
         if (bus2.pred_valid || bus3.pred_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_pred", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("pred_cycle", cyc, e.cyc);
               check("pred_valid2", bus2.pred_valid, 1);
               check("pred_valid3", bus3.pred_valid, 1);
               check("pred_ctr2", bus2.pred_ctr, e.ctr2);
               check("pred_taken2", bus2.pred_taken, int'(e.ctr2 >= 2));
               check("pred_ctr3", bus3.pred_ctr, e.ctr3);
               check("pred_taken3", bus3.pred_taken, int'(e.ctr3 >= 4));
               last2 = e.ctr2;
               last3 = e.ctr3;
            end
         end else begin
            check("hold_ctr2", bus2.pred_ctr, last2);
            check("hold_taken2", bus2.pred_taken, int'(last2 >= 2));
            check("hold_ctr3", bus3.pred_ctr, last3);
            check("hold_taken3", bus3.pred_taken, int'(last3 >= 4));
         end
      end
   end

   initial begin
      rst            = 1'b1;
      bus2.flush     = 1'b0;
      bus2.lk_valid  = 1'b0;
      bus2.lk_idx    = '0;
      bus2.upd_valid = 1'b0;
      bus2.upd_idx   = '0;
      bus2.upd_taken = 1'b0;
      m_ready = 1'b0;
      cyc     = 0;
      last2   = 0;
      last3   = 0;
      model_fill();
      #1;
      apply_reset(2);

      // Traffic during the init sweep must be ignored.
      for (int i = 0; i < ENTRIES; i++)
         cycle(1'b1, $urandom_range(0, 7), 1'b1, $urandom_range(0, 7), 1'($urandom), 1'b0);

      // Every entry reads back as weakly-not-taken.
      for (int i = 0; i < ENTRIES; i++) cycle(1'b1, i, 1'b0, 0, 1'b0, 1'b0);

      // Up to saturation and back down to zero on one entry.
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 0, 1'b1, 5, 1'b1, 1'b0);
         cycle(1'b1, 5, 1'b0, 0, 1'b0, 1'b0);
      end
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 0, 1'b1, 5, 1'b0, 1'b0);
         cycle(1'b1, 5, 1'b0, 0, 1'b0, 1'b0);
      end

      // Bypass on a shared index; independence on different indices.
      cycle(1'b1, 3, 1'b1, 3, 1'b1, 1'b0);
      cycle(1'b1, 3, 1'b1, 4, 1'b1, 1'b0);

      // Wide-counter saturation, back-to-back updates with lookups.
      for (int i = 0; i < 8; i++) cycle(1'b1, 6, 1'b1, 6, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) cycle(1'b1, 6, 1'b1, 6, 1'b0, 1'b0);

      // Flush in RUN with an update riding on it, then a flush mid-sweep.
      for (int i = 0; i < 3; i++) cycle(1'b0, 0, 1'b1, 2, 1'b1, 1'b0);
      cycle(1'b1, 2, 1'b1, 2, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b1, 2, 1'b1, 2, 1'b1, 1'b0);
      cycle(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
      idle(ENTRIES);
      cycle(1'b1, 2, 1'b0, 0, 1'b0, 1'b0);

      // Reset at sweep index 4, then reset while a prediction is on the outputs.
      cycle(1'b0, 0, 1'b0, 0, 1'b0, 1'b1);
      idle(4);
      apply_reset(1);
      idle(ENTRIES + 1);
      cycle(1'b1, 1, 1'b1, 1, 1'b1, 1'b0);
      apply_reset(2);
      idle(ENTRIES + 1);

      // Random traffic with heavy index collisions and rare flushes.
      for (int i = 0; i < 1500; i++)
         cycle(1'($urandom), $urandom_range(0, 7), 1'($urandom), $urandom_range(0, 7),
               1'($urandom), $urandom_range(0, 63) == 0);

      idle(3);
      check("scoreboard_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/branch_pattern_table.md
BRANCH_PATTERN_TABLE -- requirements
Module: branch_pattern_table

Interface
REQ-001 SHALL have parameter CTR_W, default 2: saturating counter width in bits, legal range 2..4.
REQ-002 SHALL have parameter ENTRIES, default 256: table depth, power of two, at least 4.
REQ-003 SHALL have parameter INIT_VAL, default 2**(CTR_W-1)-1: weakly-not-taken counter value loaded into every entry.
REQ-004 SHALL derive localparam IDX_W = $clog2(ENTRIES).
REQ-005 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port flush, input, 1: request to reinitialise the whole table.
REQ-008 SHALL have port ready, output, 1: table initialised; lookups and updates are accepted.
REQ-009 SHALL have port lk_valid, input, 1: lookup request.
REQ-010 SHALL have port lk_idx, input, IDX_W: lookup index.
REQ-011 SHALL have port pred_valid, output, 1: prediction outputs valid.
REQ-012 SHALL have port pred_taken, output, 1: predicted direction, equal to the counter MSB.
REQ-013 SHALL have port pred_ctr, output, CTR_W: counter value read for the lookup.
REQ-014 SHALL have port upd_valid, input, 1: update request from branch resolution.
REQ-015 SHALL have port upd_idx, input, IDX_W: update index.
REQ-016 SHALL have port upd_taken, input, 1: resolved outcome (1 = taken).

Function
REQ-017 SHALL use a two-state FSM: INIT and RUN.
REQ-018 In INIT, SHALL write INIT_VAL to one entry per cycle, sweeping from index 0 to ENTRIES-1, with ready=0.
REQ-019 SHALL enter RUN on the cycle after the write to entry ENTRIES-1, with ready=1 on that cycle.
REQ-020 Full initialisation after reset release SHALL take exactly ENTRIES cycles.
REQ-021 A flush in RUN SHALL enter INIT and restart the sweep at index 0.
REQ-022 A flush in INIT SHALL restart the sweep at index 0.
REQ-023 An update coinciding with flush SHALL be dropped.
REQ-024 Lookups and updates presented while ready=0 SHALL be ignored, with no state change and pred_valid=0 on the next cycle.
REQ-025 A lookup is accepted when lk_valid&&ready.
REQ-026 pred_valid, pred_taken and pred_ctr SHALL be registered, valid exactly 1 cycle after acceptance, and held until the next accepted lookup.
REQ-027 pred_valid SHALL be 1 for one cycle per accepted lookup, else 0.
REQ-028 An update is accepted when upd_valid&&ready&&!flush; the read-modify-write SHALL complete in that cycle.
REQ-029 On taken, the counter SHALL increment, saturating at 2**CTR_W-1.
REQ-030 On not-taken, the counter SHALL decrement, saturating at 0; no wrap-around in either direction.
REQ-031 Same-cycle lookup and update to the same index: the prediction SHALL reflect the post-update value (bypass).
REQ-032 Same-cycle lookup and update to different indices SHALL be independent.
REQ-033 Back-to-back updates to one index SHALL accumulate, each seeing the previous result.

Reset
REQ-034 rst low SHALL immediately force ready=0, pred_valid=0, pred_taken=0, pred_ctr=0, FSM=INIT and sweep index=0.
REQ-035 Table contents SHALL NOT be reset directly; the INIT sweep defines them.
REQ-036 Reset asserted mid-sweep or mid-update SHALL abort the sweep or update; the full sweep SHALL restart from 0 after release.

Structure
REQ-037 Package bp_pkg SHALL hold the FSM state enum (INIT, RUN) and the default CTR_W constant.
REQ-038 Sub-module sat_counter (parameter CTR_W) SHALL be purely combinational (cur, taken -> nxt), with the saturation rule defined only there.

Verification
REQ-039 Reset release with ENTRIES=8 -> ready=0 for 8 cycles, then ready=1; every lookup returns pred_ctr=1, pred_taken=0.
REQ-040 CTR_W=2, idx 5: four taken updates -> pred_ctr 2,3,3,3 on interleaved lookups; then three not-taken -> 2,1,0, then a further not-taken stays 0.
REQ-041 Lookup and update (taken) to idx 3 in the same cycle, entry=1 -> next cycle pred_ctr=2, pred_taken=1; same-cycle update to idx 4 -> pred_ctr of idx 3 unchanged.
REQ-042 Flush in RUN after training idx 2 to 3 -> ready=0 for ENTRIES cycles; lookup of idx 2 afterwards -> pred_ctr=INIT_VAL; update during flush dropped.
REQ-043 rst pulsed low at sweep index 4 -> outputs cleared asynchronously; ready rises exactly ENTRIES cycles after release.
REQ-044 CTR_W=3 saturation -> 8 taken updates leave 7; 8 not-taken updates leave 0; pred_taken follows bit 2.
